fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Downstream consumer of fifo_16x8: pops bytes from the FIFO read port and transmits each one as an 8N1 asynchronous serial frame on a single line.
- Acts as the drain stage of the FIFO. Provides pacing through a programmable bit period and never over-reads an empty FIFO.

Parameters:
- D_WIDTH, 8, data bits per frame; matches the FIFO width.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2 and up.
- CNT_W, 8, baud counter width; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- tx_en  input  1  enables fetching new bytes; a frame already in progress always completes.
- fifo_empty  input  1  empty flag from the FIFO.
- fifo_dout  input  D_WIDTH  FIFO read data; valid on the edge after the FIFO samples read=1.
- fifo_read  output  1  FIFO read strobe, registered, one-cycle pulse per byte.
- tx  output  1  serial line; idle high.
- busy  output  1  high whenever state is not IDLE.
- tx_done  output  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
Reset (reset=0 at a clk edge):
- State goes to IDLE.
- tx=1, fifo_read=0, busy=0, tx_done=0.
- Shift register, bit counter and baud counter all clear to 0.
- Reset has priority over all other inputs.

State machine (registered outputs):
- IDLE:
  - tx=1.
  - If tx_en=1 and fifo_empty=0, go to READ.
  - Otherwise stay in IDLE.
- READ: one cycle with fifo_read=1, then go to WAIT.
- WAIT:
  - One cycle while the FIFO updates fifo_dout.
  - At the end of WAIT, latch fifo_dout into the shift register.
  - Go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - D_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles.
  - Shift register shifts right and the bit counter increments at each bit boundary.
  - After bit D_WIDTH-1, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - tx_done=1 in the final cycle.
  - Then return to IDLE.

Timing:
- Baud counter counts 0..CLKS_PER_BIT-1 and resets on every bit boundary and every state entry.
- If fifo_read is high in cycle t, tx falls in cycle t+2.
- A frame occupies the line for exactly (D_WIDTH+2)*CLKS_PER_BIT cycles.
- Back-to-back frames: read pulses are spaced (D_WIDTH+2)*CLKS_PER_BIT+3 cycles apart, i.e. 163 at the defaults. This comprises the frame, one IDLE cycle, READ and WAIT.

Boundary conditions:
- fifo_read is never asserted unless fifo_empty=0 was sampled in IDLE in the preceding cycle. An empty FIFO yields zero read pulses.
- Exactly one fifo_read pulse is issued per transmitted frame; no double pops.
- fifo_empty and fifo_dout are ignored outside IDLE and WAIT respectively.
- tx_en=0 mid-frame:
  - The current frame completes normally, including tx_done.
  - The block then stays in IDLE with no further reads.
- tx_en=0 in READ or WAIT: the already-popped byte is still transmitted.
- Reset mid-frame: tx=1 on the next edge. The popped byte is discarded, which is accepted behaviour.
- fifo_dout changing during START, DATA or STOP has no effect on tx.

Test Plan:
- Reset: drive reset=0 for 2 cycles with fifo_empty=0 and tx_en=1 → tx=1, fifo_read=0, busy=0 and tx_done=0 throughout.
- Single byte: CLKS_PER_BIT=4, FIFO holds 8'hA5 → one fifo_read pulse. tx then carries 0,1,0,1,0,0,1,0,1,1, each held for 4 cycles, with tx falling 2 cycles after the pulse. tx_done pulses at cycle 40 of the frame and busy drops the next cycle.
- Back-to-back: FIFO loaded with 10,20,30 → three frames decode to 10,20,30. Read pulses are 43 cycles apart (CLKS_PER_BIT=4) and fifo_empty is high after the third pulse.
- Empty FIFO: fifo_empty=1, tx_en=1 for 100 cycles → zero fifo_read pulses, tx=1 and busy=0.
- Enable drop: clear tx_en during DATA of the first of two queued bytes (8'h3C) → the frame completes with data 8'h3C and no second read occurs. Re-asserting tx_en then sends the second byte.
- Reset mid-frame: assert reset=0 during bit 3 of 8'hFF → tx=1 next cycle and state is IDLE. After release, the next FIFO byte transmits cleanly.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drain stage of a byte FIFO; pops one byte at a time and sends
// it as an 8N1 frame (start 0, D_WIDTH data bits LSB first, stop 1).
// Ports:
//   clk         system clock, rising-edge
//   reset       synchronous active-low reset
//   tx_en       allows fetching new bytes; a frame in flight always completes
//   fifo_empty  FIFO empty flag, looked at only in IDLE
//   fifo_dout   FIFO read data, captured at the end of WAIT
//   fifo_read   registered one-cycle pop strobe
//   tx          serial line, idle high
//   busy        high whenever the FSM is not idle
//   tx_done     one-cycle pulse in the last cycle of the stop bit
module fifo_uart_tx #(
  parameter int unsigned D_WIDTH      = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_en,
  input  logic               fifo_empty,
  input  logic [D_WIDTH-1:0] fifo_dout,
  output logic               fifo_read,
  output logic               tx,
  output logic               busy,
  output logic               tx_done
);

  localparam int unsigned BIT_W = $clog2(D_WIDTH + 1);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(D_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   baud, baud_n;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [D_WIDTH-1:0] shreg, shreg_n;
  logic               tx_n, fifo_read_n, busy_n, tx_done_n;

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      baud      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx        <= 1'b1;
      fifo_read <= 1'b0;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      baud      <= baud_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      tx        <= tx_n;
      fifo_read <= fifo_read_n;
      busy      <= busy_n;
      tx_done   <= tx_done_n;
    end
  end

  // Next state and datapath; the baud counter restarts on every bit boundary
  // and state entry.
  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    case (state)
      S_IDLE: begin
        baud_n = '0;
        if (tx_en && !fifo_empty) state_n = S_READ;
      end
      S_READ: state_n = S_WAIT;
      S_WAIT: begin
        shreg_n   = fifo_dout;
        bit_cnt_n = '0;
        baud_n    = '0;
        state_n   = S_START;
      end
      S_START: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          state_n = S_DATA;
        end else begin
          baud_n = baud + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud == BAUD_LAST) begin
          baud_n    = '0;
          shreg_n   = shreg >> 1;
          bit_cnt_n = bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_LAST) state_n = S_STOP;
        end else begin
          baud_n = baud + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          state_n = S_IDLE;
        end else begin
          baud_n = baud + CNT_W'(1);
        end
      end
      default: begin
        baud_n  = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registers line up with it.
  always_comb begin
    tx_n        = 1'b1;
    fifo_read_n = (state_n == S_READ);
    busy_n      = (state_n != S_IDLE);
    tx_done_n   = (state_n == S_STOP) && (baud_n == BAUD_LAST);
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomized self-checking bench for fifo_uart_tx: a FIFO model feeds the DUT,
// stimulus pushes expected bytes into a scoreboard queue, and a monitor
// decodes every serial frame and checks it against the queue plus timing rules.
module tb_fifo_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned FRAME = (DW + 2) * CPB;
  localparam int unsigned GAP   = FRAME + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_read, tx, busy, tx_done;

  fifo_uart_tx #(.D_WIDTH(DW), .CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_read(fifo_read), .tx(tx), .busy(busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // FIFO model: dout is valid only on the cycle after a pop, garbage otherwise.
  logic [DW-1:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_read && rd_ptr != wr_ptr) begin
      fifo_dout <= mem[rd_ptr % 256];
      rd_ptr    <= rd_ptr + 1;
    end else begin
      fifo_dout <= DW'($urandom);
    end
  end

  logic [DW-1:0] exp_q [$];

  task automatic push(input logic [DW-1:0] b, input bit expect_tx);
    mem[wr_ptr % 256] = b;
    wr_ptr++;
    if (expect_tx) exp_q.push_back(b);
  endtask

  // Monitor state (sampled at negedge; stimulus changes just after posedge).
  int   cyc = 0;
  int   n_reads = 0;
  int   read_cyc [$];
  int   last_read = -1000;
  bit   in_frame = 0;
  bit   chk_after = 0;
  int   k = 0;
  logic bits [FRAME];
  logic prev_reset = 1'b0;
  logic prev_idle = 1'b0, prev_empty = 1'b1, prev_en = 1'b0, prev_read = 1'b0;
  logic [DW-1:0] m_got;
  bit   m_ok;

  always @(negedge clk) begin
    cyc++;
    if (!prev_reset) begin
      check("rst_tx", tx, 1);
      check("rst_read", fifo_read, 0);
      check("rst_busy", busy, 0);
      check("rst_done", tx_done, 0);
      in_frame  = 0;
      chk_after = 0;
    end else begin
      if (fifo_read === 1'b1) begin
        check("read_gate", 32'(prev_idle && !prev_empty && prev_en && !prev_read), 1);
        n_reads++;
        read_cyc.push_back(cyc);
        last_read = cyc;
      end
      if (chk_after) begin
        check("busy_after_frame", busy, 0);
        chk_after = 0;
      end
      if (!in_frame && tx === 1'b0) begin
        in_frame = 1;
        k = 0;
        check("read_to_tx_latency", 32'(cyc - last_read), 2);
        check("busy_in_frame", busy, 1);
      end
      if (in_frame) begin
        bits[k] = tx;
        check("tx_done", tx_done, 32'(k == int'(FRAME) - 1));
        if (k == int'(FRAME) - 1) begin
          m_ok = 1;
          for (int b = 0; b < int'(DW) + 2; b++)
            for (int j = 0; j < int'(CPB); j++)
              if (bits[b*CPB + j] !== bits[b*CPB]) m_ok = 0;
          check("bit_stable", 32'(m_ok), 1);
          check("start_bit", bits[0], 0);
          check("stop_bit", bits[(DW+1)*CPB], 1);
          for (int i = 0; i < int'(DW); i++) m_got[i] = bits[(i+1)*CPB];
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_frame: got %02h, expected no frame", m_got);
          end else begin
            check("frame_data", m_got, exp_q.pop_front());
          end
          in_frame  = 0;
          chk_after = 1;
        end
        k++;
      end else if (tx_done !== 1'b0) begin
        check("tx_done_idle", tx_done, 0);
      end
    end
    prev_reset = reset;
    prev_idle  = !busy;
    prev_empty = fifo_empty;
    prev_en    = tx_en;
    prev_read  = fifo_read;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && busy == 1'b0 && fifo_empty && !in_frame) && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 32'(n < budget), 1);
  endtask

  task automatic wait_tx_low(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < budget);
    check("wait_tx_low", tx, 0);
  endtask

  initial begin
    int r0;
    // Reset held with data available and enable high.
    reset = 1'b0;
    tx_en = 1'b1;
    push(8'h5A, 1);
    tick(2);
    reset = 1'b1;
    wait_drain("drain_after_reset", 200);

    // Single byte.
    r0 = n_reads;
    push(8'hA5, 1);
    wait_drain("drain_single", 200);
    check("single_reads", 32'(n_reads - r0), 1);

    // Back-to-back frames and read spacing.
    r0 = n_reads;
    push(8'd10, 1);
    push(8'd20, 1);
    push(8'd30, 1);
    wait_drain("drain_b2b", 400);
    check("b2b_reads", 32'(n_reads - r0), 3);
    check("b2b_gap1", 32'(read_cyc[$-1] - read_cyc[$-2]), GAP);
    check("b2b_gap2", 32'(read_cyc[$] - read_cyc[$-1]), GAP);

    // Empty FIFO never produces a read.
    r0 = n_reads;
    tick(100);
    check("empty_reads", 32'(n_reads - r0), 0);
    check("empty_busy", busy, 0);
    check("empty_tx", tx, 1);

    // Enable dropped mid-frame: frame completes, no further pop.
    r0 = n_reads;
    push(8'h3C, 1);
    push(8'h77, 1);
    wait_tx_low(20);
    tick(8);
    tx_en = 1'b0;
    tick(60);
    check("endrop_reads", 32'(n_reads - r0), 1);
    check("endrop_pending", 32'(exp_q.size()), 1);
    check("endrop_busy", busy, 0);
    tx_en = 1'b1;
    wait_drain("drain_endrop", 200);
    check("endrop_reads_after", 32'(n_reads - r0), 2);

    // Reset during data bit 3 of 0xFF; that byte is dropped.
    push(8'hFF, 0);
    push(8'h81, 1);
    wait_tx_low(20);
    tick(17);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    wait_drain("drain_midreset", 300);

    // Randomized bursts with random enable drops.
    for (int r = 0; r < 10; r++) begin
      int nb = $urandom_range(1, 3);
      for (int i = 0; i < nb; i++) push(8'($urandom), 1);
      tick($urandom_range(0, 60));
      if ($urandom_range(0, 1) == 1) begin
        tx_en = 1'b0;
        tick($urandom_range(1, 50));
        tx_en = 1'b1;
      end
    end
    wait_drain("drain_random", 2000);

    check("exp_left", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
